// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Sequential instruction prefetcher in front of the core's instr/instr_addr
//   pair. It issues word requests ahead of the PC (up to DEPTH outstanding),
//   keeps them in a circular queue, and presents the word for the current
//   instr_addr with a valid flag. Any PC discontinuity flushes the queue and
//   discards the responses of requests still in flight.
//
// Configuration macro:
//   IFQ_BYPASS_EN - when defined, a response that targets the unfilled head
//                   entry is forwarded to instr in the same cycle.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   instr_addr     current PC from the core
//   advance        core consumes instr this cycle (ignored unless instr_valid)
//   instr          instruction word for instr_addr (zero when not valid)
//   instr_valid    instr is valid for the current instr_addr
//   mem_req_valid  request to instruction memory
//   mem_req_ready  memory accepts the request
//   mem_req_addr   word address of the request
//   mem_resp_valid response present; one per accepted request, in order
//   mem_resp_data  response word
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  input  logic        advance,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_OCC = DEPTH[PW+1:0];

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  logic [31:0]      entry_addr [DEPTH];
  logic [31:0]      entry_data [DEPTH];
  logic [DEPTH-1:0] entry_filled;

  ptr_t        head;
  ptr_t        tail;
  cnt_t        count;
  cnt_t        filled_cnt;
  cnt_t        drop_cnt;
  logic [31:0] fetch_addr;

  logic          mismatch;
  logic          head_filled;
  logic          fill_en;
  logic          discard_en;
  logic          bypass_hit;
  logic          push;
  logic          pop;
  ptr_t          fill_idx;
  logic [PW+1:0] occupancy;
  cnt_t          unfilled_left;
  cnt_t          drop_left;

  // Responses return in order, so the filled entries always form a prefix of
  // the queue starting at head; filled_cnt locates the oldest unfilled entry.
  always_comb begin
    mismatch    = (count == '0) ? (fetch_addr != instr_addr)
                                : (entry_addr[head] != instr_addr);
    head_filled = entry_filled[head];
    fill_en     = mem_resp_valid && (drop_cnt == '0) && (filled_cnt < count);
    discard_en  = mem_resp_valid && (drop_cnt != '0);
    fill_idx    = head + filled_cnt[PW-1:0];
    occupancy   = {1'b0, count} + {1'b0, drop_cnt};

`ifdef IFQ_BYPASS_EN
    // No filled entries means the fill lands on the head itself.
    bypass_hit  = fill_en && (filled_cnt == '0);
`else
    bypass_hit  = 1'b0;
`endif

    mem_req_valid = !reset && !mismatch && (occupancy < DEPTH_OCC);
    mem_req_addr  = fetch_addr;
    instr_valid   = !reset && !mismatch && (head_filled || bypass_hit);
    instr         = '0;
    if (instr_valid) begin
      instr = head_filled ? entry_data[head] : mem_resp_data;
    end

    push = mem_req_valid && mem_req_ready;
    pop  = instr_valid && advance;

    // Responses still owed after a flush: earlier stale ones not yet drained
    // plus entries left unfilled once this cycle's response has landed.
    unfilled_left = count - filled_cnt - cnt_t'(fill_en);
    drop_left     = drop_cnt - cnt_t'(discard_en);
  end

  // Queue control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      filled_cnt   <= '0;
      drop_cnt     <= '0;
      fetch_addr   <= '0;
      entry_filled <= '0;
    end else if (mismatch) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      filled_cnt   <= '0;
      entry_filled <= '0;
      drop_cnt     <= drop_left + unfilled_left;
      fetch_addr   <= instr_addr;
    end else begin
      if (push) begin
        entry_filled[tail] <= 1'b0;
        tail               <= tail + ptr_t'(1);
        fetch_addr         <= fetch_addr + 32'd4;
      end
      if (fill_en) begin
        entry_filled[fill_idx] <= 1'b1;
      end
      // With bypass the head may be filled and retired together; the clear
      // must win over the set.
      if (pop) begin
        entry_filled[head] <= 1'b0;
        head               <= head + ptr_t'(1);
      end
      count      <= count + cnt_t'(push) - cnt_t'(pop);
      filled_cnt <= filled_cnt + cnt_t'(fill_en) - cnt_t'(pop);
      drop_cnt   <= drop_left;
    end
  end

  // Entry payload; validity is tracked by the control state above.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[tail] <= fetch_addr;
    end
    if (fill_en) begin
      entry_data[fill_idx] <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue
//   Directed bench for instr_fetch_queue. An environment process plays both
//   the core (PC that advances on each retired instruction, jumps on request)
//   and a fixed-latency instruction memory whose word at address a is
//   a ^ 32'hDEAD0000. Expected request addresses and retired instructions are
//   queued by the stimulus and consumed by the monitor half of that process.
module tb_instr_fetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_addr = '0;
  logic        advance = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ins_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rst_end = 4;
  int          release_cyc = 0;
  int          lat = 1;
  int          pop_total = 0;
  int          target_pops = 0;
  int          jump_id = 0;
  int          jump_seen = 0;
  logic [31:0] jump_tgt = '0;
  logic        popped = 1'b0;
  pend_t       pend[$];
  ins_t        exp_ins[$];
  logic [31:0] exp_req[$];
  int          pop_cyc[$];

  instr_fetch_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_addr     (instr_addr),
    .advance        (advance),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Core and memory drive at posedge+1, the monitor samples at negedge.
  initial begin : env
    ins_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < rst_end) begin
        reset          = 1'b1;
        instr_addr     = '0;
        advance        = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
      end else begin
        if (reset) release_cyc = cyc;
        reset = 1'b0;
        if (jump_seen != jump_id) begin
          instr_addr = jump_tgt;
          jump_seen  = jump_id;
        end else if (popped) begin
          instr_addr = instr_addr + 32'd4;
        end
        advance = (pop_total < target_pops);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = pend[0].addr ^ 32'hDEAD0000;
          void'(pend.pop_front());
        end else begin
          mem_resp_valid = 1'b0;
          mem_resp_data  = '0;
        end
      end
      popped = 1'b0;

      @(negedge clk);
      if (reset) begin
        pend.delete();
      end else begin
        if (mem_req_valid && mem_req_ready) begin
          pend.push_back('{mem_req_addr, cyc + lat});
          if (exp_req.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_unexpected: got request %h, expected none", mem_req_addr);
          end else begin
            checkOutput("req_addr", mem_req_addr, exp_req.pop_front());
          end
        end
        if (instr_valid && advance) begin
          popped = 1'b1;
          pop_total++;
          pop_cyc.push_back(cyc);
          if (exp_ins.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL pop_unexpected: got instr %h at %h, expected none", instr, instr_addr);
          end else begin
            e = exp_ins.pop_front();
            checkOutput("pop_addr", instr_addr, e.addr);
            checkOutput("pop_data", instr, e.data);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic expectInstr(input logic [31:0] a, input logic [31:0] d);
    exp_ins.push_back('{a, d});
  endtask

  task automatic expectReq(input logic [31:0] a);
    exp_req.push_back(a);
  endtask

  task automatic applyStimulus(input logic do_jump, input logic [31:0] tgt,
                               input int new_lat, input int n_instr);
    lat = new_lat;
    if (do_jump) begin
      jump_tgt = tgt;
      jump_id++;
    end
    target_pops = pop_total + n_instr;
  endtask

  task automatic waitBudget(input string name);
    int n = 0;
    while (pop_total < target_pops && n < 200) begin
      tick(1);
      n++;
    end
    if (pop_total < target_pops) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: timeout with %0d instructions retired, expected %0d",
               name, pop_total, target_pops);
      target_pops = pop_total;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    mem_req_ready = 1'b1;

    // Reset held for three cycles, then sequential fetch from 0.
    for (int i = 0; i < 12; i++) expectReq(32'(i * 4));
    for (int i = 0; i < 8; i++) expectInstr(32'(i * 4), 32'hDEAD0000 | 32'(i * 4));
    tick(2);
    checkOutput("rst_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_req_addr", mem_req_addr, 32'd0);
    checkOutput("rst_count", 32'(dut.count), 32'd0);
    checkOutput("rst_drop_cnt", 32'(dut.drop_cnt), 32'd0);
    applyStimulus(1'b0, 32'd0, 1, 8);
    waitBudget("seq_run");
    if (pop_cyc.size() >= 8) begin
      checkOutput("first_valid_latency", 32'(pop_cyc[0] - release_cyc), 32'(EXP_LAT));
      checkOutput("steady_one_per_cycle", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL pop_count: got %0d pops, expected 8", pop_cyc.size());
    end

    // Core stalls: queue fills to DEPTH and requests stop.
    tick(4);
    checkOutput("full_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("full_count", 32'(dut.count), 32'd4);
    checkOutput("full_instr_valid", 32'(instr_valid), 32'd1);
    checkOutput("full_instr", instr, 32'hDEAD0020);

    // One pop from a full queue: request only in the following cycle.
    expectInstr(32'h20, 32'hDEAD0020);
    expectReq(32'h30);
    applyStimulus(1'b0, 32'd0, 1, 1);
    tick(1);
    checkOutput("pop_cycle_req_valid", 32'(mem_req_valid), 32'd0);
    tick(1);
    checkOutput("after_pop_req_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("after_pop_req_addr", mem_req_addr, 32'h30);
    tick(3);

    // Jump to 0x8, then to 0x100 while 0x8 and 0xC are in flight.
    expectReq(32'h8);
    expectReq(32'hC);
    for (int i = 0; i < 6; i++) expectReq(32'h100 + 32'(i * 4));
    expectInstr(32'h100, 32'hDEAD0100);
    expectInstr(32'h104, 32'hDEAD0104);
    applyStimulus(1'b1, 32'h8, 3, 0);
    tick(3);
    applyStimulus(1'b1, 32'h100, 3, 0);
    tick(1);
    checkOutput("jump_instr_valid", 32'(instr_valid), 32'd0);
    tick(1);
    checkOutput("jump_drop_cnt_2", 32'(dut.drop_cnt), 32'd2);
    checkOutput("jump_req_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("jump_req_addr", mem_req_addr, 32'h100);
    tick(2);
    checkOutput("jump_drop_cnt_0", 32'(dut.drop_cnt), 32'd0);
    checkOutput("stale_instr_valid", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 32'd0, 3, 2);
    waitBudget("jump_run");
    tick(6);

    // Sequential fetch across the 32-bit address wrap.
    expectReq(32'hFFFF_FFF8);
    expectReq(32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) expectReq(32'(i * 4));
    expectInstr(32'hFFFF_FFF8, 32'h2152_FFF8);
    expectInstr(32'hFFFF_FFFC, 32'h2152_FFFC);
    expectInstr(32'h0, 32'hDEAD0000);
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1, 3);
    waitBudget("wrap_run");
    tick(4);
    checkOutput("wrap_full_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("wrap_head_instr", instr, 32'hDEAD0004);

    // Reset pulse with three requests outstanding.
    expectReq(32'h200);
    expectReq(32'h204);
    expectReq(32'h208);
    applyStimulus(1'b1, 32'h200, 5, 0);
    tick(4);
    rst_end = cyc + 2;
    lat = 1;
    for (int i = 0; i < 6; i++) expectReq(32'(i * 4));
    expectInstr(32'h0, 32'hDEAD0000);
    expectInstr(32'h4, 32'hDEAD0004);
    tick(1);
    checkOutput("in_rst_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("in_rst_instr_valid", 32'(instr_valid), 32'd0);
    tick(1);
    checkOutput("post_rst_req_addr", mem_req_addr, 32'd0);
    checkOutput("post_rst_req_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("post_rst_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("post_rst_instr", instr, 32'd0);
    checkOutput("post_rst_count", 32'(dut.count), 32'd0);
    checkOutput("post_rst_drop_cnt", 32'(dut.drop_cnt), 32'd0);
    applyStimulus(1'b0, 32'd0, 1, 2);
    waitBudget("post_rst_run");
    tick(4);

    checkOutput("req_left_over", 32'(exp_req.size()), 32'd0);
    checkOutput("instr_left_over", 32'(exp_ins.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
